// File: rtl/rem_sched_if.sv
// Bundles the reminder scheduler's request, handshake and status signals.
// master: requester/consumer side (drives set/dur/cancel/ack).
// slave : scheduler side (drives notif/notif_id/busy/pend).
//   set      [N]     per-slot arm/re-arm strobe
//   dur      [N*DW]  packed durations, slot i at dur[i*DW +: DW]
//   cancel   [N]     per-slot cancel strobe
//   ack              consumer accepts the presented notification
//   notif            notification valid
//   notif_id [IDW]   slot index of the presented notification
//   busy     [N]     slot armed and counting
//   pend     [N]     slot expired, awaiting delivery
interface rem_sched_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = 32,
  parameter int unsigned IDW = 2
) ();
  logic [N-1:0]    set;
  logic [N*DW-1:0] dur;
  logic [N-1:0]    cancel;
  logic            ack;
  logic            notif;
  logic [IDW-1:0]  notif_id;
  logic [N-1:0]    busy;
  logic [N-1:0]    pend;

  modport master (
    output set, dur, cancel, ack,
    input  notif, notif_id, busy, pend
  );

  modport slave (
    input  set, dur, cancel, ack,
    output notif, notif_id, busy, pend
  );
endinterface

// File: rtl/rem_sched.sv
// Multi-slot reminder scheduler: N independent countdown slots whose expiries
// share one notification output, granted round-robin with a ready/ack handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rem_sched_if.slave (set/dur/cancel/ack in, notif/notif_id/busy/pend out)
module rem_sched #(
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = 32,
  parameter int unsigned IDW = 2
) (
  input logic        clk,
  input logic        rst,
  rem_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } slot_state_e;

  slot_state_e    state_q [N];
  slot_state_e    state_d [N];
  logic [DW-1:0]  cnt_q   [N];
  logic [DW-1:0]  cnt_d   [N];
  logic [DW-1:0]  dur_i;
  logic [N-1:0]   busy_q, busy_d;
  logic [N-1:0]   pend_q, pend_d;

  logic           notif_q, notif_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] ptr_after;
  logic [IDW-1:0] search_start;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] grant_id;
  logic           grant_found;
  logic [N-1:0]   elig;
  logic           acked;

  // An ack only counts while a notification is actually presented.
  assign acked = notif_q & bus.ack;

  // Per-slot next state: cancel beats set, set beats delivery and counting.
  always_comb begin
    dur_i  = '0;
    busy_d = '0;
    pend_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      dur_i      = bus.dur[i*DW +: DW];
      if (bus.cancel[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else if (bus.set[i]) begin
        state_d[i] = ARMED;
        cnt_d[i]   = (dur_i == '0) ? DW'(1) : dur_i;
      end else if (acked && (id_q == IDW'(i))) begin
        state_d[i] = IDLE;
      end else if (state_q[i] == ARMED) begin
        if (cnt_q[i] == DW'(1)) begin
          state_d[i] = EXPIRED;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - DW'(1);
        end
      end
      busy_d[i] = (state_d[i] == ARMED);
      pend_d[i] = (state_d[i] == EXPIRED);
    end
  end

  // Round-robin grant. Eligibility uses the current pend flags, so a slot that
  // expires at this edge waits one more cycle; the acked slot is excluded so
  // back-to-back grants move on to the next pending slot.
  always_comb begin
    notif_d      = notif_q;
    id_d         = id_q;
    ptr_d        = ptr_q;
    cand         = '0;
    grant_id     = '0;
    grant_found  = 1'b0;
    ptr_after    = IDW'((32'(id_q) + 32'd1) % N);
    elig         = pend_q & ~bus.cancel & ~bus.set;
    if (acked) begin
      elig[id_q] = 1'b0;
    end
    search_start = acked ? ptr_after : ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDW'((32'(search_start) + k) % N);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end

    if (notif_q) begin
      if (bus.ack) begin
        ptr_d   = ptr_after;
        notif_d = grant_found;
        if (grant_found) begin
          id_d = grant_id;
        end
      end else if (bus.cancel[id_q] || bus.set[id_q]) begin
        notif_d = 1'b0;
      end
    end else if (grant_found) begin
      notif_d = 1'b1;
      id_d    = grant_id;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      busy_q  <= '0;
      pend_q  <= '0;
      notif_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      notif_q <= notif_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.notif    = notif_q;
  assign bus.notif_id = id_q;
  assign bus.busy     = busy_q;
  assign bus.pend     = pend_q;

endmodule

// File: tb/tb_rem_sched.sv
// Self-checking bench for rem_sched: directed vector table plus hand-written
// sequences for long counts, re-arm, and reset during activity.
module tb_rem_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  rem_sched_if #(.N(N), .DW(DW), .IDW(IDW)) bus ();

  rem_sched #(.N(N), .DW(DW), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  set;
    logic [31:0] d;
    logic [3:0]  cancel;
    logic        ack;
    logic        notif;
    logic [1:0]  id;
    logic [3:0]  busy;
    logic [3:0]  pend;
  } vec_t;

  vec_t tv [$];

  // Drive one cycle of inputs; every set slot receives duration d.
  task automatic drive(input logic [3:0] s, input logic [31:0] d,
                       input logic [3:0] c, input logic a);
    bus.set    = s;
    bus.cancel = c;
    bus.ack    = a;
    bus.dur    = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) bus.dur[i*32 +: 32] = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {notif, notif_id, busy, pend} against the expected tuple.
  task automatic chk(input string name, input logic n, input logic [1:0] id,
                     input logic [3:0] b, input logic [3:0] p);
    logic [10:0] got;
    logic [10:0] exp;
    got = {bus.notif, bus.notif_id, bus.busy, bus.pend};
    exp = {n, id, b, p};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got notif=%b id=%0d busy=%b pend=%b, expected notif=%b id=%0d busy=%b pend=%b",
               name, got[10], got[9:8], got[7:4], got[3:0], exp[10], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 32'd0, 4'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_state", 1'b0, 2'd0, 4'b0, 4'b0);
  endtask

  initial begin
    drive(4'b0, 32'd0, 4'b0, 1'b0);

    // Vector table, applied from a fresh reset (pointer at slot 0).
    //            set      dur     cancel  ack   notif id    busy     pend
    tv.push_back('{4'b0111, 32'd2, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0111, 4'b0000}); // arm 0,1,2
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0111, 4'b0000});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0111}); // all expire
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0111}); // ack ignored, grant 0
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 4'b0110}); // back-to-back
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0100});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000}); // ptr=3
    tv.push_back('{4'b1001, 32'd1, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b1001, 4'b0000}); // fairness
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b1001});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b1001}); // slot 3 first
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0001});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000}); // ptr=1
    tv.push_back('{4'b0010, 32'd1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0010, 4'b0000}); // cancel presented
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0010});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010});
    tv.push_back('{4'b0000, 32'd0, 4'b0010, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000});
    tv.push_back('{4'b0001, 32'd5, 4'b0001, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000}); // set+cancel
    tv.push_back('{4'b0100, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0100, 4'b0000}); // dur=0
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0100});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0100});
    tv.push_back('{4'b0100, 32'd3, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0000}); // re-arm presented
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0000});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0000});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0100});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0100});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000}); // ptr=3
    tv.push_back('{4'b0010, 32'd1, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000}); // expiry vs ack
    tv.push_back('{4'b0001, 32'd3, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0001, 4'b0010});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0001, 4'b0010});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0001, 4'b0010});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0001}); // slot 0 not yet eligible
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0001});
    tv.push_back('{4'b0000, 32'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000});

    do_reset();

    // Single slot with a long duration.
    drive(4'b0001, 32'd45, 4'b0, 1'b0);
    tick();
    chk("long_armed", 1'b0, 2'd0, 4'b0001, 4'b0000);
    drive(4'b0, 32'd0, 4'b0, 1'b0);
    for (int c = 0; c < 44; c++) begin
      tick();
      chk("long_counting", 1'b0, 2'd0, 4'b0001, 4'b0000);
    end
    tick();
    chk("long_expired", 1'b0, 2'd0, 4'b0000, 4'b0001);
    tick();
    chk("long_notif", 1'b1, 2'd0, 4'b0000, 4'b0001);
    drive(4'b0, 32'd0, 4'b0, 1'b1);
    tick();
    chk("long_acked", 1'b0, 2'd0, 4'b0000, 4'b0000);
    drive(4'b0, 32'd0, 4'b0, 1'b0);

    // Reset while three slots are armed and a notification is presented.
    drive(4'b0001, 32'd1, 4'b0, 1'b0);
    tick();
    chk("mid_arm0", 1'b0, 2'd0, 4'b0001, 4'b0000);
    drive(4'b1110, 32'd50, 4'b0, 1'b0);
    tick();
    chk("mid_arm123", 1'b0, 2'd0, 4'b1110, 4'b0001);
    drive(4'b0, 32'd0, 4'b0, 1'b0);
    tick();
    chk("mid_notif", 1'b1, 2'd0, 4'b1110, 4'b0001);
    rst = 1'b1;
    tick();
    chk("mid_reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      chk("post_reset_quiet", 1'b0, 2'd0, 4'b0000, 4'b0000);
    end

    // Table from a fresh reset.
    do_reset();
    for (int r = 0; r < tv.size(); r++) begin
      drive(tv[r].set, tv[r].d, tv[r].cancel, tv[r].ack);
      tick();
      chk($sformatf("vec%0d", r), tv[r].notif, tv[r].id, tv[r].busy, tv[r].pend);
    end
    drive(4'b0, 32'd0, 4'b0, 1'b0);

    // Re-arm mid-count: dur 20, then 5 edges later dur 8 -> expiry 8 edges after reload.
    drive(4'b0100, 32'd20, 4'b0, 1'b0);
    tick();
    chk("rearm_first", 1'b0, 2'd0, 4'b0100, 4'b0000);
    drive(4'b0, 32'd0, 4'b0, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    drive(4'b0100, 32'd8, 4'b0, 1'b0);
    tick();
    chk("rearm_reload", 1'b0, 2'd0, 4'b0100, 4'b0000);
    drive(4'b0, 32'd0, 4'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("rearm_counting", 1'b0, 2'd0, 4'b0100, 4'b0000);
    end
    tick();
    chk("rearm_expired", 1'b0, 2'd0, 4'b0000, 4'b0100);
    tick();
    chk("rearm_notif", 1'b1, 2'd2, 4'b0000, 4'b0100);
    drive(4'b0, 32'd0, 4'b0, 1'b1);
    tick();
    chk("rearm_acked", 1'b0, 2'd2, 4'b0000, 4'b0000);
    drive(4'b0, 32'd0, 4'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rem_sched.md
Name: rem_sched

Overview:
Multi-slot reminder scheduler. It accepts up to N independent reminder requests, each with its own duration, and counts each one down in a dedicated slot. Expired reminders share a single notification output, which a round-robin arbiter grants with a ready/ack handshake. The block sits between several user-facing requesters and the single alert/display path.

Parameters:
N, 4, number of reminder slots/requesters (2..16)
DW, 32, duration counter width in clk cycles
IDW, 2, width of slot index (must equal clog2(N))

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
set  input  N  per-slot arm/re-arm strobe, sampled each edge
dur  input  N*DW  packed durations; slot i uses dur[i*DW +: DW], sampled when set[i]=1
cancel  input  N  per-slot cancel strobe
ack  input  1  consumer accepts the presented notification
notif  output  1  notification valid (Alert)
notif_id  output  IDW  slot index of presented notification; valid only when notif=1
busy  output  N  slot i armed (counting)
pend  output  N  slot i expired, awaiting delivery (includes the presented slot)

Behaviour:
- Reset (rst=1 at edge): all slots IDLE, counters 0, notif=0, notif_id=0, busy=0, pend=0, round-robin pointer=0 (slot 0 has highest priority first). Reset overrides all inputs. Reset mid-count or mid-handshake discards everything.
- Per-slot FSM has states IDLE, ARMED and EXPIRED. busy[i]=ARMED and pend[i]=EXPIRED; both are registered.
- Arming: set[i]=1 at edge k loads cnt_i=max(dur_i,1) and moves the slot to ARMED. A dur of 0 is treated as 1.
- Counting: each later edge decrements cnt_i. At the edge where cnt_i==1, the slot goes to EXPIRED. pend[i] is therefore first high after edge k+max(dur,1).
- set[i] in any state reloads and re-arms (restart). If the slot is EXPIRED, its pending alert is discarded. If it is currently presented, notif is withdrawn at the same edge.
- cancel[i] in any state moves the slot to IDLE at that edge. If the slot is presented, notif drops at that edge. cancel wins over set in the same cycle.
- Arbiter:
  - If notif=0 and any pend bit is set (excluding slots cancelled or set this edge), at that edge: notif<=1, notif_id<=first pending index found searching from ptr upward with wrap.
  - notif and notif_id hold stable until ack, cancel or set on that slot.
- Handshake: ack=1 while notif=1 moves slot notif_id to IDLE and sets ptr<=notif_id+1 (mod N).
  - If another slot is pending at the same edge, the next grant is made in that same edge: notif stays 1 and notif_id changes. This gives one notification per cycle back-to-back.
  - Otherwise notif<=0.
- ack while notif=0 is ignored. A slot that expires in the same edge as an ack is not eligible until the next edge.
- Minimum latency from expiry to notif is 1 cycle: pend rises at edge e, notif rises at edge e+1 if the output is free.
- Counter is DW bits and never wraps. The largest duration is 2^DW-1.

Test Plan:
- Reset then single slot: rst high 2 cycles, set[0]=1 with dur0=45 for one cycle -> busy[0]=1 for 45 cycles; pend[0] rises 45 edges after set; notif=1 and notif_id=0 one edge later; ack one cycle -> notif=0 and pend[0]=0 next edge.
- Simultaneous expiry and round-robin: set slots 0,1,2 with dur=10 in the same cycle -> pend=3'b111 together; ack held high -> notif_id 0,1,2 on consecutive cycles; notif low after 3 acks; ptr=3.
- Fairness: ptr=3, slots 0 and 3 pending -> slot 3 is granted first, then slot 0.
- Cancel and re-arm: cancel[1] while presented -> notif=0 next edge, slot 1 IDLE. set[2] dur=20 at cycle 5 then set[2] dur=8 at cycle 10 -> pend[2] after edge 18 only.
- Edge cases: dur=0 -> pend after 1 edge. set and cancel on the same slot in the same cycle -> slot stays IDLE. ack with notif=0 -> no change.
- Reset mid-operation: rst asserted while 3 slots armed and notif=1 -> all outputs 0 next edge. No stale alert appears after rst is released.
